mul_seq_ctrl: RTL

- Control unit (initiator) for the 8-bit sequential shift-and-add unsigned multiplier datapath.
- Drives the load, clear, add, shift and bus-drive strobes of the A, Q and M registers.
- Sequences operand intake from ibus, N add/shift iterations and result readout onto obus.
- Exposes a start/busy/done handshake to the system sequencer.

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_iter_cnt.sv | 28 ++
 rtl/mul_seq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the controller state encoding and default sizing.
package mul_pkg;

    localparam int N_DEF  = 8;
    localparam int CW_DEF = $clog2(N_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_Q,
        TEST,
        SHIFT,
        OUT_A,
        OUT_Q,
        DONE
    } state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the add/shift loop.
// Sync clear wins over increment; last flags index N-1.
module mul_iter_cnt
    import mul_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(N - 1));

    // Counter register: clear on reset or request, else step.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Control unit for the 8-bit shift-and-add multiplier.
// Strobes are registered against the next state.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          q0,
    output logic          ld_m_ibus,
    output logic          ld_q_ibus,
    output logic          clr_a,
    output logic          add_a,
    output logic          sh_r,
    output logic          ld_a_obus,
    output logic          ld_q_obus,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    state_t state;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   last;

    // q0 only gates the add strobe, and only in TEST.
    assign add_a = (state == TEST) & q0;

    assign cnt_clr = (state == LOAD_Q) ||
                     ((state == SHIFT) && last);
    assign cnt_inc = (state == SHIFT) && !last;

    mul_iter_cnt #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (last)
    );

    // State register; each branch also sets the next state's strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ld_m_ibus <= 1'b0;
            ld_q_ibus <= 1'b0;
            clr_a     <= 1'b0;
            sh_r      <= 1'b0;
            ld_a_obus <= 1'b0;
            ld_q_obus <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ld_m_ibus <= 1'b0;
            ld_q_ibus <= 1'b0;
            clr_a     <= 1'b0;
            sh_r      <= 1'b0;
            ld_a_obus <= 1'b0;
            ld_q_obus <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_M;
                        ld_m_ibus <= 1'b1;
                        clr_a     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD_M: begin
                    state     <= LOAD_Q;
                    ld_q_ibus <= 1'b1;
                end
                LOAD_Q: begin
                    state <= TEST;
                end
                TEST: begin
                    state <= SHIFT;
                    sh_r  <= 1'b1;
                end
                SHIFT: begin
                    if (last) begin
                        state     <= OUT_A;
                        ld_a_obus <= 1'b1;
                    end else begin
                        state <= TEST;
                    end
                end
                OUT_A: begin
                    state     <= OUT_Q;
                    ld_q_obus <= 1'b1;
                end
                OUT_Q: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
